// File: rtl/wb_trace_buffer.sv
// Retire-trace capture: circular FWFT buffer of writeback retirements with overflow and halt flags.
// Optional shadow register file enabled by defining WB_TRACE_SHADOW_EN.
module wb_trace_buffer #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            wb_valid,
  input  logic [XLEN-1:0] wb_pc,
  input  logic [31:0]     wb_ir,
  input  logic            wb_we,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  input  logic            rd_en,
  output logic            rd_valid,
  output logic [XLEN-1:0] rd_pc,
  output logic [31:0]     rd_ir,
  output logic            rd_we,
  output logic [4:0]      rd_rd,
  output logic [XLEN-1:0] rd_data,
  output logic [AW:0]     count,
  output logic            overflow,
  output logic            halted,
  output logic [31:0]     retire_cnt
`ifdef WB_TRACE_SHADOW_EN
  ,
  input  logic [4:0]      sh_addr,
  output logic [XLEN-1:0] sh_data
`endif
);

  localparam logic [AW:0] CountFull = (AW+1)'(DEPTH);

  typedef enum logic [0:0] {StRun, StHalt} state_e;
  state_e state_q, state_d;

  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q, count_d;
  logic          overflow_q;
  logic [31:0]   retire_cnt_q;

  logic [XLEN-1:0] pc_mem   [DEPTH];
  logic [31:0]     ir_mem   [DEPTH];
  logic            we_mem   [DEPTH];
  logic [4:0]      rd_mem   [DEPTH];
  logic [XLEN-1:0] data_mem [DEPTH];

  logic accept, pop, full, is_halt, store_we;

  assign accept   = wb_valid & ~halted;
  assign pop      = rd_en & rd_valid;
  assign full     = (count_q == CountFull);
  assign is_halt  = (wb_ir == 32'h0000006f) || (wb_ir == 32'h00000073);
  assign store_we = wb_we & (wb_rd != 5'd0);

  // FSM: state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= StRun;
    else     state_q <= state_d;
  end

  // FSM: next state; the halting retire itself is still accepted and recorded
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StRun:   if (accept && is_halt) state_d = StHalt;
      StHalt:  state_d = StHalt;
      default: state_d = StRun;
    endcase
  end

  // FSM: outputs
  always_comb begin
    halted = (state_q == StHalt);
  end

  always_comb begin
    count_d = count_q;
    if (accept && !pop && !full) count_d = count_q + (AW+1)'(1);
    else if (pop && !accept)     count_d = count_q - (AW+1)'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      overflow_q   <= 1'b0;
      retire_cnt_q <= '0;
    end else begin
      count_q <= count_d;
      if (accept) begin
        wr_ptr_q     <= wr_ptr_q + AW'(1);
        retire_cnt_q <= retire_cnt_q + 32'd1;
      end
      // When full, an unpopped accept overwrites the oldest entry, so the read side moves too
      if (pop || (accept && full)) rd_ptr_q <= rd_ptr_q + AW'(1);
      if (accept && full && !pop) overflow_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      pc_mem[wr_ptr_q]   <= wb_pc;
      ir_mem[wr_ptr_q]   <= wb_ir;
      we_mem[wr_ptr_q]   <= store_we;
      rd_mem[wr_ptr_q]   <= wb_rd;
      data_mem[wr_ptr_q] <= wb_data;
    end
  end

  always_comb begin
    rd_valid = (count_q != '0);
    rd_pc    = '0;
    rd_ir    = '0;
    rd_we    = 1'b0;
    rd_rd    = '0;
    rd_data  = '0;
    if (rd_valid) begin
      rd_pc   = pc_mem[rd_ptr_q];
      rd_ir   = ir_mem[rd_ptr_q];
      rd_we   = we_mem[rd_ptr_q];
      rd_rd   = rd_mem[rd_ptr_q];
      rd_data = data_mem[rd_ptr_q];
    end
  end

  assign count      = count_q;
  assign overflow   = overflow_q;
  assign retire_cnt = retire_cnt_q;

`ifdef WB_TRACE_SHADOW_EN
  logic [XLEN-1:0] shadow_q [32];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) shadow_q[i] <= '0;
    end else if (accept && store_we) begin
      shadow_q[wb_rd] <= wb_data;
    end
  end

  assign sh_data = (sh_addr == 5'd0) ? '0 : shadow_q[sh_addr];
`endif

endmodule
